// File: rtl/hangman_main.sv
// Two-keypad hangman game controller.
// The host spells a word of up to 8 letters with multi-tap keys and sends it to the player side.
// The player then guesses letters until the word is fully revealed (WIN) or 6 misses (LOSE).
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   role_switch_i             0 = host keypad live, 1 = player keypad live
//   input_row_host_i[3:0]     host keys (bit3/2/1 letters, bit0 submit), 1 = pressed
//   input_row_player_i[3:0]   player keys, same layout
//   red_o/green_o/blue_o      LOSE / WIN / PLAY indicators
//   error_o                   last accepted key event was illegal
//   msg_sent_o                one-cycle pulse when the host word is handed over
//   host_row1_o..play_row2_o  16-char ASCII LCD lines, char 0 in [127:120]
module hangman_main (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         role_switch_i,
    input  logic [3:0]   input_row_host_i,
    input  logic [3:0]   input_row_player_i,
    output logic         red_o,
    output logic         green_o,
    output logic         blue_o,
    output logic         error_o,
    output logic         msg_sent_o,
    output logic [127:0] host_row1_o,
    output logic [127:0] host_row2_o,
    output logic [127:0] play_row1_o,
    output logic [127:0] play_row2_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPlay = 2'd1;
    localparam logic [1:0] StWin  = 2'd2;
    localparam logic [1:0] StLose = 2'd3;

    localparam logic [7:0] ChA  = 8'h41;
    localparam logic [7:0] ChZ  = 8'h5A;
    localparam logic [7:0] ChSp = 8'h20;
    localparam logic [7:0] ChUs = 8'h5F;

    function automatic logic [7:0] tap_base(input logic [1:0] key);
        case (key)
            2'd3:    return 8'h41;  // 'A'
            2'd2:    return 8'h47;  // 'G'
            default: return 8'h50;  // 'P'
        endcase
    endfunction

    function automatic logic [7:0] tap_next(input logic [7:0] cur, input logic [1:0] key);
        logic [7:0] nxt;
        nxt = cur + ((key == 2'd3) ? 8'd4 : 8'd1);
        return (nxt > ChZ) ? ChA : nxt;
    endfunction

    // Highest pressed key wins if several rise together.
    function automatic logic [1:0] key_idx(input logic [3:0] ev);
        if (ev[3])      return 2'd3;
        else if (ev[2]) return 2'd2;
        else if (ev[1]) return 2'd1;
        else            return 2'd0;
    endfunction

    // Key synchroniser and edge detector. All stages reset to 1 so a key held through
    // reset looks "already pressed" and must be released before it can fire again.
    logic [7:0] sync1_q, sync2_q, prev_q, rise;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= {input_row_player_i, input_row_host_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

    logic [3:0] host_ev, play_ev;
    logic       h_any, p_any;
    logic [1:0] h_key, p_key;

    assign host_ev = role_switch_i ? 4'd0 : rise[3:0];
    assign play_ev = role_switch_i ? rise[7:4] : 4'd0;
    assign h_any   = |host_ev;
    assign p_any   = |play_ev;
    assign h_key   = key_idx(host_ev);
    assign p_key   = key_idx(play_ev);

    logic [1:0]      state_q, state_d;
    logic [7:0][7:0] hbuf_q, hbuf_d, word_q, word_d;
    logic [3:0]      hlen_q, hlen_d, wlen_q, wlen_d;
    logic            hp_v_q, hp_v_d, pp_v_q, pp_v_d;
    logic [7:0]      hp_c_q, hp_c_d, pp_c_q, pp_c_d;
    logic [1:0]      hp_k_q, hp_k_d, pp_k_q, pp_k_d;
    logic [7:0]      rev_q, rev_d;
    logic [25:0]     guess_q, guess_d;
    logic [2:0]      miss_q, miss_d;
    logic            error_q, error_d, msg_sent_q, msg_sent_d;

    logic [7:0] len_mask, hit;
    logic [4:0] g_off;

    assign g_off = 5'(pp_c_q - ChA);

    // Parallel compare of the pending guess against every word position.
    always_comb begin
        len_mask = '0;
        hit      = '0;
        for (int i = 0; i < 8; i++) begin
            len_mask[i] = (4'(i) < wlen_q);
            hit[i]      = len_mask[i] && (word_q[i] == pp_c_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        hbuf_d     = hbuf_q;
        hlen_d     = hlen_q;
        hp_v_d     = hp_v_q;
        hp_c_d     = hp_c_q;
        hp_k_d     = hp_k_q;
        pp_v_d     = pp_v_q;
        pp_c_d     = pp_c_q;
        pp_k_d     = pp_k_q;
        word_d     = word_q;
        wlen_d     = wlen_q;
        rev_d      = rev_q;
        guess_d    = guess_q;
        miss_d     = miss_q;
        error_d    = error_q;
        msg_sent_d = 1'b0;

        if (h_any) begin
            if (h_key != 2'd0) begin
                if (state_q == StIdle) begin
                    error_d = 1'b0;
                    if (hp_v_q && hp_k_q == h_key) begin
                        hp_c_d = tap_next(hp_c_q, h_key);
                    end else begin
                        hp_v_d = 1'b1;
                        hp_k_d = h_key;
                        hp_c_d = tap_base(h_key);
                    end
                end else begin
                    error_d = 1'b1;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (hp_v_q) begin
                            hp_v_d = 1'b0;
                            if (hlen_q == 4'd8) begin
                                error_d = 1'b1;  // buffer full, letter dropped
                            end else begin
                                hbuf_d[hlen_q[2:0]] = hp_c_q;
                                hlen_d              = hlen_q + 4'd1;
                                error_d             = 1'b0;
                            end
                        end else if (hlen_q == 4'd0) begin
                            error_d = 1'b1;
                        end else begin
                            word_d     = hbuf_q;
                            wlen_d     = hlen_q;
                            rev_d      = '0;
                            guess_d    = '0;
                            miss_d     = '0;
                            pp_v_d     = 1'b0;
                            msg_sent_d = 1'b1;
                            state_d    = StPlay;
                            error_d    = 1'b0;
                        end
                    end
                    StPlay: error_d = 1'b1;
                    default: begin
                        hbuf_d  = '0;
                        hlen_d  = '0;
                        hp_v_d  = 1'b0;
                        pp_v_d  = 1'b0;
                        word_d  = '0;
                        wlen_d  = '0;
                        rev_d   = '0;
                        guess_d = '0;
                        miss_d  = '0;
                        state_d = StIdle;
                        error_d = 1'b0;
                    end
                endcase
            end
        end else if (p_any) begin
            if (p_key != 2'd0) begin
                error_d = 1'b0;
                if (pp_v_q && pp_k_q == p_key) begin
                    pp_c_d = tap_next(pp_c_q, p_key);
                end else begin
                    pp_v_d = 1'b1;
                    pp_k_d = p_key;
                    pp_c_d = tap_base(p_key);
                end
            end else if (state_q != StPlay || !pp_v_q) begin
                error_d = 1'b1;
            end else begin
                pp_v_d = 1'b0;
                if (guess_q[g_off]) begin
                    error_d = 1'b1;  // repeated guess costs nothing
                end else begin
                    error_d        = 1'b0;
                    guess_d[g_off] = 1'b1;
                    if (|hit) begin
                        rev_d = rev_q | hit;
                        if ((rev_q | hit | ~len_mask) == 8'hFF) state_d = StWin;
                    end else begin
                        miss_d = miss_q + 3'd1;
                        if (miss_q == 3'd5) state_d = StLose;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            hbuf_q     <= '0;
            hlen_q     <= '0;
            hp_v_q     <= 1'b0;
            hp_c_q     <= '0;
            hp_k_q     <= '0;
            pp_v_q     <= 1'b0;
            pp_c_q     <= '0;
            pp_k_q     <= '0;
            word_q     <= '0;
            wlen_q     <= '0;
            rev_q      <= '0;
            guess_q    <= '0;
            miss_q     <= '0;
            error_q    <= 1'b0;
            msg_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hbuf_q     <= hbuf_d;
            hlen_q     <= hlen_d;
            hp_v_q     <= hp_v_d;
            hp_c_q     <= hp_c_d;
            hp_k_q     <= hp_k_d;
            pp_v_q     <= pp_v_d;
            pp_c_q     <= pp_c_d;
            pp_k_q     <= pp_k_d;
            word_q     <= word_d;
            wlen_q     <= wlen_d;
            rev_q      <= rev_d;
            guess_q    <= guess_d;
            miss_q     <= miss_d;
            error_q    <= error_d;
            msg_sent_q <= msg_sent_d;
        end
    end

    // Display rows: index 15 holds char 0 so the packed row maps straight onto [127:120].
    logic [15:0][7:0] hr1, hr2, pr1, pr2;

    always_comb begin
        hr1 = {16{ChSp}};
        pr1 = {16{ChSp}};
        for (int i = 0; i < 16; i++) begin
            if (i < 8 && 4'(i) < hlen_q) hr1[15-i] = hbuf_q[i[2:0]];
            else if (hp_v_q && 4'(i) == hlen_q) hr1[15-i] = hp_c_q;
        end
        for (int i = 0; i < 8; i++) begin
            if (len_mask[i]) begin
                pr1[15-i] = (state_q == StLose || rev_q[i]) ? word_q[i] : ChUs;
            end
        end
        hr2 = (state_q == StIdle) ? "ENTER WORD      " : "SENT            ";
        case (state_q)
            StPlay: begin
                pr2    = "MISSES:         ";
                pr2[8] = 8'h30 + {5'd0, miss_q};
            end
            StWin:   pr2 = "YOU WIN         ";
            StLose:  pr2 = "YOU LOSE        ";
            default: pr2 = "WAIT            ";
        endcase
    end

    assign host_row1_o = hr1;
    assign host_row2_o = hr2;
    assign play_row1_o = pr1;
    assign play_row2_o = pr2;
    assign blue_o      = (state_q == StPlay);
    assign green_o     = (state_q == StWin);
    assign red_o       = (state_q == StLose);
    assign error_o     = error_q;
    assign msg_sent_o  = msg_sent_q;

endmodule

// File: tb/tb_hangman_main.sv
// Randomised scoreboard bench for hangman_main against a string/array game model.
module tb_hangman_main;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         role_switch = 1'b0;
    logic [3:0]   row_h = 4'd0;
    logic [3:0]   row_p = 4'd0;
    logic         red, green, blue, err_w, msg_w;
    logic [127:0] hr1, hr2, pr1, pr2;

    always #5 clk = ~clk;

    hangman_main dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .role_switch_i     (role_switch),
        .input_row_host_i  (row_h),
        .input_row_player_i(row_p),
        .red_o             (red),
        .green_o           (green),
        .blue_o            (blue),
        .error_o           (err_w),
        .msg_sent_o        (msg_w),
        .host_row1_o       (hr1),
        .host_row2_o       (hr2),
        .play_row1_o       (pr1),
        .play_row2_o       (pr2)
    );

    typedef struct {
        logic         red, green, blue, err;
        int           msgs;
        logic [127:0] hr1, hr2, pr1, pr2;
    } snap_t;

    snap_t snap_q[$];
    int    checks = 0;
    int    errors = 0;
    int    msgs_seen = 0;
    logic  chk_req = 1'b0;

    // Game model: 0 idle, 1 play, 2 win, 3 lose.
    int         m_st;
    logic [7:0] hbuf[$];
    logic [7:0] word[$];
    int         hpend, hkey, ppend, pkey;
    bit         rev[8];
    bit         guessed[26];
    int         misses;
    bit         merr;
    int         mmsgs = 0;

    task automatic model_clear();
        m_st = 0;
        hbuf.delete();
        word.delete();
        hpend = -1;
        ppend = -1;
        foreach (rev[i]) rev[i] = 1'b0;
        foreach (guessed[i]) guessed[i] = 1'b0;
        misses = 0;
    endtask

    task automatic do_tap(inout int pend, inout int key, input int k);
        if (pend >= 0 && key == k) begin
            pend += (k == 3) ? 4 : 1;
            if (pend > 90) pend = 65;
        end else begin
            key  = k;
            pend = (k == 3) ? 65 : (k == 2) ? 71 : 80;
        end
    endtask

    task automatic model_key(input bit player, input int k);
        if (!player) begin
            if (k != 0) begin
                if (m_st == 0) begin
                    merr = 1'b0;
                    do_tap(hpend, hkey, k);
                end else merr = 1'b1;
            end else if (m_st == 0) begin
                if (hpend >= 0) begin
                    if (hbuf.size() == 8) merr = 1'b1;
                    else begin
                        hbuf.push_back(8'(hpend));
                        merr = 1'b0;
                    end
                    hpend = -1;
                end else if (hbuf.size() == 0) merr = 1'b1;
                else begin
                    word = hbuf;
                    foreach (rev[i]) rev[i] = 1'b0;
                    foreach (guessed[i]) guessed[i] = 1'b0;
                    misses = 0;
                    ppend  = -1;
                    mmsgs++;
                    m_st = 1;
                    merr = 1'b0;
                end
            end else if (m_st == 1) merr = 1'b1;
            else begin
                model_clear();
                merr = 1'b0;
            end
        end else begin
            if (k != 0) begin
                merr = 1'b0;
                do_tap(ppend, pkey, k);
            end else if (m_st != 1 || ppend < 0) merr = 1'b1;
            else begin
                int c;
                bit hit;
                bit all;
                c = ppend;
                ppend = -1;
                if (guessed[c-65]) merr = 1'b1;
                else begin
                    merr = 1'b0;
                    guessed[c-65] = 1'b1;
                    hit = 1'b0;
                    foreach (word[i]) if (int'(word[i]) == c) begin
                        rev[i] = 1'b1;
                        hit = 1'b1;
                    end
                    if (hit) begin
                        all = 1'b1;
                        foreach (word[i]) if (!rev[i]) all = 1'b0;
                        if (all) m_st = 2;
                    end else begin
                        misses++;
                        if (misses == 6) m_st = 3;
                    end
                end
            end
        end
    endtask

    function automatic logic [127:0] row_str(input string s);
        logic [127:0] r;
        r = {16{8'h20}};
        for (int i = 0; i < s.len() && i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.red   = (m_st == 3);
        s.green = (m_st == 2);
        s.blue  = (m_st == 1);
        s.err   = merr;
        s.msgs  = mmsgs;
        s.hr1   = {16{8'h20}};
        foreach (hbuf[i]) s.hr1[127-8*i -: 8] = hbuf[i];
        if (hpend >= 0) s.hr1[127-8*hbuf.size() -: 8] = 8'(hpend);
        s.hr2 = row_str((m_st == 0) ? "ENTER WORD" : "SENT");
        s.pr1 = {16{8'h20}};
        foreach (word[i]) s.pr1[127-8*i -: 8] = (m_st == 3 || rev[i]) ? word[i] : 8'h5F;
        case (m_st)
            1:       s.pr2 = row_str($sformatf("MISSES:%0d", misses));
            2:       s.pr2 = row_str("YOU WIN");
            3:       s.pr2 = row_str("YOU LOSE");
            default: s.pr2 = row_str("WAIT");
        endcase
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now();
        snap_q.push_back(model_snap());
        chk_req = 1'b1;
        tick(1);
        chk_req = 1'b0;
    endtask

    task automatic press(input bit player, input int k, input int hold);
        if (role_switch != player) begin
            role_switch = player;
            tick(2);
        end
        if (player) row_p[k] = 1'b1;
        else row_h[k] = 1'b1;
        tick(hold);
        row_p = 4'd0;
        row_h = 4'd0;
        tick(4);
        model_key(player, k);
        expect_now();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        merr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic cmp_bit(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, a, e);
        end
    endtask

    task automatic cmp_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic cmp_row(input string name, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, a, e);
        end
    endtask

    // Monitor: counts msg_sent pulses and checks the DUT whenever a response is due.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (msg_w === 1'b1) msgs_seen++;
            if (chk_req) begin
                if (snap_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got empty queue expected an entry");
                end else begin
                    e = snap_q.pop_front();
                    cmp_bit("red", red, e.red);
                    cmp_bit("green", green, e.green);
                    cmp_bit("blue", blue, e.blue);
                    cmp_bit("error", err_w, e.err);
                    cmp_int("msg_sent_pulses", msgs_seen, e.msgs);
                    cmp_row("host_row1", hr1, e.hr1);
                    cmp_row("host_row2", hr2, e.hr2);
                    cmp_row("play_row1", pr1, e.pr1);
                    cmp_row("play_row2", pr2, e.pr2);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pl;
        model_clear();
        merr = 1'b0;
        tick(3);
        expect_now();
        rst_n = 1'b1;
        tick(2);
        expect_now();

        // Word "AE".
        press(0, 3, 2); press(0, 0, 2); press(0, 3, 2); press(0, 3, 3);
        press(0, 0, 2); press(0, 0, 2);
        // Guess E then A -> win, then host returns to idle.
        press(1, 3, 2); press(1, 3, 2); press(1, 0, 2);
        press(1, 3, 2); press(1, 0, 2);
        press(0, 0, 2);

        // Word "AE" again, six distinct misses P..U -> lose.
        press(0, 3, 2); press(0, 0, 2); press(0, 3, 2); press(0, 3, 2);
        press(0, 0, 2); press(0, 0, 2);
        for (int n = 1; n <= 6; n++) begin
            for (int t = 0; t < n; t++) press(1, 1, 2);
            press(1, 0, 2);
        end
        press(0, 0, 2);

        // Empty word commit, 9th letter drop, repeat guesses, host key in play, bare submit.
        press(0, 0, 2);
        for (int i = 0; i < 9; i++) begin
            for (int t = 0; t <= i % 3; t++) press(0, 2, 2);
            press(0, 0, 2);
        end
        press(0, 0, 2);
        press(1, 2, 2); press(1, 0, 2);
        press(1, 2, 2); press(1, 0, 2);
        press(1, 1, 2); press(1, 0, 2);
        press(1, 1, 2); press(1, 0, 2);
        press(0, 3, 2);
        press(1, 0, 2);

        // Random play, biased toward whichever keypad matters in the current state.
        for (int n = 0; n < 400; n++) begin
            case (m_st)
                0:       pl = ($urandom_range(0, 9) == 0) ? 1 : 0;
                1:       pl = ($urandom_range(0, 9) == 0) ? 0 : 1;
                default: pl = $urandom_range(0, 1);
            endcase
            press(pl[0], $urandom_range(0, 3), $urandom_range(1, 4));
        end

        // Long hold gives one event; three bit1 presses give 'R'.
        do_reset();
        expect_now();
        press(0, 1, 1000);
        press(0, 1, 2);
        press(0, 1, 2);

        // Reset while a key is held: no event until it is released and pressed again.
        role_switch = 1'b0;
        row_h[3] = 1'b1;
        tick(5);
        model_key(0, 3);
        expect_now();
        rst_n = 1'b0;
        model_clear();
        merr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        expect_now();
        row_h = 4'd0;
        tick(4);
        expect_now();
        press(0, 3, 2);

        tick(3);
        cmp_int("scoreboard_drain", snap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
